dvp_pattern_gen: RTL and testbench

Parametrised multi-camera DVP source model. It is the next generation of the fixed two-camera DVP imitator used in the HDR capture benches. It emits VSYNC/HREF framing and 4:2:2 YCbCr byte streams for NUM_CAM cameras from a selectable test pattern, with configurable resolution, blanking and per-camera brightness offset. It drives `convert2avl_stream`-class receivers in simulation and on-board loopback tests.

---
 rtl/dvp_pattern_gen.sv | 189 ++++++++++++++++++
 tb/tb_dvp_pattern_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_pattern_gen.sv
// Multi-camera DVP source: VSYNC/HREF framing plus 4:2:2 YCbCr byte lanes
// (Cb,Y0,Cr,Y1) generated from ramp, colour-bar, flat or PRBS patterns.
module dvp_pattern_gen #(
    parameter int DATA_W      = 8,
    parameter int NUM_CAM     = 2,
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int H_BLANK     = 64,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2,
    parameter int CAM_STEP    = 16,
    parameter int NUM_FRAMES  = 0
) (
    input  logic                      pclk,
    input  logic                      reset,
    input  logic                      run_test,
    input  logic                      stop_test,
    input  logic [1:0]                mode,
    output logic                      VSYNC,
    output logic                      HREF,
    output logic [NUM_CAM*DATA_W-1:0] D,
    output logic [15:0]               frame_cnt,
    output logic                      busy,
    output logic [2:0]                dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_VS   = 3'd1,
        S_VBP  = 3'd2,
        S_ACT  = 3'd3,
        S_HBL  = 3'd4,
        S_VFP  = 3'd5
    } state_t;

    localparam int          LINE     = 2 * H_ACTIVE + H_BLANK;
    localparam logic [31:0] VS_LAST  = 32'(VSYNC_LINES * LINE - 1);
    localparam logic [31:0] VBP_LAST = 32'(V_BACK * LINE - 1);
    localparam logic [31:0] ACT_LAST = 32'(2 * H_ACTIVE - 1);
    localparam logic [31:0] HBL_LAST = 32'(H_BLANK - 1);
    localparam logic [31:0] VFP_LAST = 32'(V_FRONT * LINE - 1);
    localparam logic [15:0] V_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] FRAMES   = 16'(NUM_FRAMES);
    localparam logic [31:0] Y_MAX    = 32'((1 << DATA_W) - 1);
    localparam logic [DATA_W-1:0] MID = DATA_W'(1 << (DATA_W - 1));
    localparam logic [15:0] SEED     = 16'hACE1;

    state_t                    state_q, state_d;
    logic [31:0]               h_cnt_q, h_cnt_d;
    logic [15:0]               v_cnt_q, v_cnt_d;
    logic [15:0]               frame_cnt_q, frame_cnt_d;
    logic                      stop_pend_q, stop_pend_d;
    logic [1:0]                mode_q, mode_d;
    logic [15:0]               lfsr_q, lfsr_d;
    logic [NUM_CAM*DATA_W-1:0] d_d;

    logic [31:0]       pix, bar, y_sum, y_cam;
    logic [DATA_W-1:0] y_base, cb, cr;
    logic              prbs;

    always_comb begin
        state_d     = state_q;
        h_cnt_d     = h_cnt_q + 32'd1;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        stop_pend_d = stop_pend_q | (stop_test && state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                h_cnt_d = '0;
                if (run_test) begin
                    state_d     = S_VS;
                    frame_cnt_d = '0;
                    mode_d      = mode;
                end
            end
            S_VS: if (h_cnt_q == VS_LAST) begin
                state_d = S_VBP;
                h_cnt_d = '0;
            end
            S_VBP: if (h_cnt_q == VBP_LAST) begin
                state_d = S_ACT;
                h_cnt_d = '0;
                v_cnt_d = '0;
            end
            S_ACT: if (h_cnt_q == ACT_LAST) begin
                state_d = S_HBL;
                h_cnt_d = '0;
            end
            S_HBL: if (h_cnt_q == HBL_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    state_d = S_VFP;
                end else begin
                    state_d = S_ACT;
                    v_cnt_d = v_cnt_q + 16'd1;
                end
            end
            S_VFP: if (h_cnt_q == VFP_LAST) begin
                h_cnt_d     = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
                // A stop raised on this very clock still ends the run here.
                if (stop_pend_d || (NUM_FRAMES != 0 && frame_cnt_d == FRAMES)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_VS;
                    mode_d  = mode;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) stop_pend_d = 1'b0;

        lfsr_d = lfsr_q;
        if (state_d == S_VS && state_q != S_VS) begin
            lfsr_d = SEED;
        end else if (state_d == S_ACT) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Byte content for the clock being registered, derived from next-state counters.
    always_comb begin
        pix    = h_cnt_d >> 1;
        bar    = pix / 32'(H_ACTIVE / 8);
        y_base = MID;
        cb     = MID;
        cr     = MID;
        prbs   = (mode_d == 2'd3);
        case (mode_d)
            2'd0: y_base = DATA_W'(pix + 32'(v_cnt_d));
            2'd1: begin
                y_base = DATA_W'(bar << (DATA_W - 3));
                cb     = ~y_base;
                cr     = y_base;
            end
            2'd2: y_base = MID;
            default: begin
                y_base = DATA_W'(lfsr_q);
                cb     = y_base;
                cr     = y_base;
            end
        endcase
        d_d   = '0;
        y_sum = '0;
        y_cam = '0;
        for (int k = 0; k < NUM_CAM; k++) begin
            y_sum = 32'(y_base) + (prbs ? 32'd0 : 32'(k * CAM_STEP));
            y_cam = (y_sum > Y_MAX) ? Y_MAX : y_sum;
            if (state_d == S_ACT) begin
                d_d[k*DATA_W +: DATA_W] = h_cnt_d[0] ? DATA_W'(y_cam)
                                                     : (h_cnt_d[1] ? cr : cb);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            stop_pend_q <= 1'b0;
            mode_q      <= 2'd0;
            lfsr_q      <= SEED;
            VSYNC       <= 1'b0;
            HREF        <= 1'b0;
            D           <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            stop_pend_q <= stop_pend_d;
            mode_q      <= mode_d;
            lfsr_q      <= lfsr_d;
            VSYNC       <= (state_d == S_VS);
            HREF        <= (state_d == S_ACT);
            D           <= d_d;
            busy        <= (state_d != S_IDLE);
        end
    end

    assign frame_cnt   = frame_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// Directed bench for dvp_pattern_gen: framing, ramp/flat/bars/PRBS bytes,
// saturation, continuous run with stop, and mid-frame reset.
module tb_dvp_pattern_gen;

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic       run_a = 1'b0;
    logic       run_c = 1'b0;
    logic       stop_c = 1'b0;
    logic [1:0] mode = 2'd0;

    logic        vs_a, hr_a, busy_a, vs_s, hr_s, busy_s, vs_c, hr_c, busy_c;
    logic [15:0] d_a, d_s, d_c, fc_a, fc_s, fc_c;
    logic [2:0]  st_a, st_s, st_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    dvp_pattern_gen #(.DATA_W(8), .NUM_CAM(2), .H_ACTIVE(8), .V_ACTIVE(3), .H_BLANK(2),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .CAM_STEP(16), .NUM_FRAMES(1)) dut (
        .pclk(pclk), .reset(reset), .run_test(run_a), .stop_test(1'b0), .mode(mode),
        .VSYNC(vs_a), .HREF(hr_a), .D(d_a), .frame_cnt(fc_a), .busy(busy_a),
        .dbg_state_o(st_a));

    dvp_pattern_gen #(.DATA_W(8), .NUM_CAM(2), .H_ACTIVE(8), .V_ACTIVE(3), .H_BLANK(2),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .CAM_STEP('h90), .NUM_FRAMES(1)) dut_sat (
        .pclk(pclk), .reset(reset), .run_test(run_a), .stop_test(1'b0), .mode(mode),
        .VSYNC(vs_s), .HREF(hr_s), .D(d_s), .frame_cnt(fc_s), .busy(busy_s),
        .dbg_state_o(st_s));

    dvp_pattern_gen #(.DATA_W(8), .NUM_CAM(2), .H_ACTIVE(8), .V_ACTIVE(3), .H_BLANK(2),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .CAM_STEP(16), .NUM_FRAMES(0)) dut_cont (
        .pclk(pclk), .reset(reset), .run_test(run_c), .stop_test(stop_c), .mode(mode),
        .VSYNC(vs_c), .HREF(hr_c), .D(d_c), .frame_cnt(fc_c), .busy(busy_c),
        .dbg_state_o(st_c));

    logic        cap_vs[300];
    logic        cap_hr[300];
    logic [15:0] cap_d[300];
    logic [15:0] cap_ds[300];
    logic [15:0] cap_fc[300];
    int          cap_len;

    logic [7:0] exp_ramp0[16] = '{8'h80, 8'h01, 8'h80, 8'h02, 8'h80, 8'h03, 8'h80, 8'h04,
                                  8'h80, 8'h05, 8'h80, 8'h06, 8'h80, 8'h07, 8'h80, 8'h08};
    logic [7:0] exp_ramp1[16] = '{8'h80, 8'h11, 8'h80, 8'h12, 8'h80, 8'h13, 8'h80, 8'h14,
                                  8'h80, 8'h15, 8'h80, 8'h16, 8'h80, 8'h17, 8'h80, 8'h18};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    // Pulse run_a and record one frame; index 0 is the first cycle after acceptance.
    task automatic run_and_capture(input logic [1:0] m);
        mode  = m;
        run_a = 1'b1;
        tick();
        run_a   = 1'b0;
        cap_len = 300;
        for (int i = 0; i < 300; i++) begin
            cap_vs[i] = vs_a;
            cap_hr[i] = hr_a;
            cap_d[i]  = d_a;
            cap_ds[i] = d_s;
            cap_fc[i] = fc_a;
            if (!busy_a) begin
                cap_len = i;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int vs_cnt, hr_cnt, hr_rises, first_hr;

        repeat (3) tick();
        check("rst_vsync", {31'd0, vs_a}, 32'd0);
        check("rst_href", {31'd0, hr_a}, 32'd0);
        check("rst_d", {16'd0, d_a}, 32'd0);
        check("rst_frame_cnt", {16'd0, fc_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Ramp framing and data
        run_and_capture(2'd0);
        vs_cnt = 0; hr_cnt = 0; hr_rises = 0; first_hr = -1;
        for (int i = 0; i < cap_len; i++) begin
            if (cap_vs[i]) vs_cnt++;
            if (cap_hr[i]) begin
                hr_cnt++;
                if (first_hr < 0) first_hr = i;
                if (i == 0 || !cap_hr[i-1]) hr_rises++;
            end
        end
        check("busy_len", 32'(cap_len), 32'd108);
        check("vsync_first", {31'd0, cap_vs[0]}, 32'd1);
        check("vsync_len", 32'(vs_cnt), 32'd18);
        check("first_href", 32'(first_hr), 32'd36);
        check("href_clocks", 32'(hr_cnt), 32'd48);
        check("href_pulses", 32'(hr_rises), 32'd3);
        check("href_gap0", {31'd0, cap_hr[52]}, 32'd0);
        check("href_gap1", {31'd0, cap_hr[53]}, 32'd0);
        check("href_line1", {31'd0, cap_hr[54]}, 32'd1);
        check("fc_before_exit", {16'd0, cap_fc[107]}, 32'd0);
        check("fc_after_exit", {16'd0, cap_fc[108]}, 32'd1);
        check("d_zero_vbp", {16'd0, cap_d[35]}, 32'd0);
        check("d_zero_hbl", {16'd0, cap_d[52]}, 32'd0);
        for (int h = 0; h < 16; h++) begin
            check($sformatf("ramp_l1_cam0_%0d", h), {24'd0, cap_d[54+h][7:0]}, {24'd0, exp_ramp0[h]});
            check($sformatf("ramp_l1_cam1_%0d", h), {24'd0, cap_d[54+h][15:8]}, {24'd0, exp_ramp1[h]});
        end
        check("ramp_l0_y0", {24'd0, cap_d[37][7:0]}, 32'h00);
        check("ramp_l2_y7", {24'd0, cap_d[87][7:0]}, 32'h09);
        tick();

        // Flat with saturation on the 0x90-step instance
        run_and_capture(2'd2);
        check("flat_cam0_cb", {24'd0, cap_ds[36][7:0]}, 32'h80);
        check("flat_cam1_cb", {24'd0, cap_ds[36][15:8]}, 32'h80);
        check("flat_cam0_y", {24'd0, cap_ds[37][7:0]}, 32'h80);
        check("sat_cam1_y", {24'd0, cap_ds[37][15:8]}, 32'hFF);
        check("sat_cam1_cr", {24'd0, cap_ds[38][15:8]}, 32'h80);
        check("sat_cam1_ylast", {24'd0, cap_ds[51][15:8]}, 32'hFF);
        check("flat_step16_cam1_y", {24'd0, cap_d[37][15:8]}, 32'h90);
        check("sat_d_zero_hbl", {16'd0, cap_ds[52]}, 32'd0);
        tick();

        // Colour bars, line 0
        run_and_capture(2'd1);
        check("bars_pix0_cb", {24'd0, cap_d[36][7:0]}, 32'hFF);
        check("bars_pix0_y", {24'd0, cap_d[37][7:0]}, 32'h00);
        check("bars_pix0_y_cam1", {24'd0, cap_d[37][15:8]}, 32'h10);
        check("bars_pix6_cb", {24'd0, cap_d[48][7:0]}, 32'h3F);
        check("bars_pix6_y", {24'd0, cap_d[49][7:0]}, 32'hC0);
        check("bars_pix7_cr", {24'd0, cap_d[50][7:0]}, 32'hE0);
        check("bars_pix7_cr_cam1", {24'd0, cap_d[50][15:8]}, 32'hE0);
        check("bars_pix7_y", {24'd0, cap_d[51][7:0]}, 32'hE0);
        check("bars_pix7_y_cam1", {24'd0, cap_d[51][15:8]}, 32'hF0);
        tick();

        // Continuous run, stop mid frame 2, runs while busy / at IDLE entry ignored
        mode  = 2'd0;
        run_c = 1'b1;
        tick();
        run_c = 1'b0;
        for (int i = 0; i <= 220; i++) begin
            if (i == 107) check("cont_fc_107", {16'd0, fc_c}, 32'd0);
            if (i == 108) begin
                check("cont_fc_108", {16'd0, fc_c}, 32'd1);
                check("cont_vs_108", {31'd0, vs_c}, 32'd1);
                check("cont_busy_108", {31'd0, busy_c}, 32'd1);
            end
            if (i == 170) begin
                check("cont_fc_ignored_run", {16'd0, fc_c}, 32'd1);
                check("cont_busy_170", {31'd0, busy_c}, 32'd1);
            end
            if (i == 215) check("cont_busy_215", {31'd0, busy_c}, 32'd1);
            if (i == 216) begin
                check("cont_busy_216", {31'd0, busy_c}, 32'd0);
                check("cont_fc_216", {16'd0, fc_c}, 32'd2);
                check("cont_vs_216", {31'd0, vs_c}, 32'd0);
            end
            if (i == 220) begin
                check("cont_busy_220", {31'd0, busy_c}, 32'd0);
                check("cont_fc_220", {16'd0, fc_c}, 32'd2);
            end
            stop_c = (i == 150);
            run_c  = (i == 160) || (i == 215);
            tick();
        end
        run_c  = 1'b0;
        stop_c = 1'b0;

        // PRBS, then reset during ACT and restart
        mode  = 2'd3;
        run_a = 1'b1;
        tick();
        run_a = 1'b0;
        repeat (36) tick();
        check("prbs_first_cam0", {24'd0, d_a[7:0]}, 32'hE1);
        check("prbs_first_cam1", {24'd0, d_a[15:8]}, 32'hE1);
        tick();
        check("prbs_second_cam0", {24'd0, d_a[7:0]}, 32'hC3);
        repeat (3) tick();
        check("pre_reset_href", {31'd0, hr_a}, 32'd1);
        reset = 1'b1;
        tick();
        check("midrst_href", {31'd0, hr_a}, 32'd0);
        check("midrst_vsync", {31'd0, vs_a}, 32'd0);
        check("midrst_d", {16'd0, d_a}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_busy", {31'd0, busy_a}, 32'd0);
        run_a = 1'b1;
        tick();
        run_a = 1'b0;
        check("restart_vsync", {31'd0, vs_a}, 32'd1);
        repeat (36) tick();
        check("restart_prbs_cam0", {24'd0, d_a[7:0]}, 32'hE1);
        check("restart_prbs_cam1", {24'd0, d_a[15:8]}, 32'hE1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
